gsim_gen: RTL and testbench
===========================

# gsim_gen

Parametrised Gauss-Seidel solver for the symmetric 7-band system M·x = b, with bands 20, −13, +6, −1 on the diagonal and offsets ±1, ±2, ±3. It is the next-generation GSIM core. It generalises the fixed 16-unknown solver to N unknowns and configurable fixed-point widths. It adds run-time iteration limit, convergence-tolerance early exit, input/output handshakes and status outputs. It sits between the b-vector stream source and the x-vector consumer.

## Interface
- N, 16, number of unknowns (≥4)
- BW, 16, signed integer width of b
- FRAC, 16, fraction bits of x
- XW, 32, signed width of x (Q(XW−FRAC).FRAC)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- in_en  in  1  b_in valid
- b_in  in  BW  signed b word, index order 0..N−1
- in_ready  out  1  block accepts b words
- iter_max  in  8  maximum sweeps; sampled with b[0]; 0 is treated as 1
- tol  in  XW  unsigned convergence threshold in Q.FRAC; sampled with b[0]
- out_valid  out  1  x_out valid
- x_out  out  XW  signed x word, index order 0..N−1
- out_ready  in  1  consumer accepts x_out
- busy  out  1  high in SWEEP and OUT
- iter_cnt  out  8  sweeps performed for the current block; held through OUT
- converged  out  1  exit was by tolerance, not by iter_max; held through OUT

## Operation
- FSM states: IDLE, LOAD, SWEEP, OUT.
- IDLE → LOAD on the first accepted word.
- LOAD → SWEEP after word N−1 is accepted.
- SWEEP → OUT at the end of a sweep when max|Δ| ≤ tol or sweep count = iter_max.
- OUT → IDLE after word N−1 is handshaken.
- Accept rule: a word is taken when in_en && in_ready. in_ready = (state ∈ {IDLE, LOAD}). in_en while in_ready=0 is ignored.
- On accepting b[0]: clear all x registers to 0, iter_cnt to 0, converged to 0; latch iter_max and tol.
- SWEEP processes one index i per cycle, for i = 0..N−1.
- The x array is updated in place at the end of each cycle, so index i uses the already-updated x[0..i−1]. This is true Gauss-Seidel.
- Update equation: S = (b_i <<< FRAC) + 13(x_{i−1}+x_{i+1}) − 6(x_{i−2}+x_{i+2}) + (x_{i−3}+x_{i+3}).
- Any x index outside 0..N−1 contributes 0.
- S is signed, XW+6 bits wide, and must not overflow.
- x_new = (S·52429) >>> 20: an arithmetic shift (floor division), approximating S/20.
- x_new saturates to the signed XW range.
- Δ = |x_new − x_old|, XW+1 bits. A running max of Δ is cleared at the start of each sweep.
- At i = N−1: iter_cnt increments. converged is set if max|Δ| (including this cycle) ≤ tol.
- OUT: x_out = x[k], with k advancing on out_valid && out_ready. x_out is held stable while out_ready=0.

## Timing
- Reset values: in_ready=1, out_valid=0, x_out=0, busy=0, iter_cnt=0, converged=0. FSM resets to IDLE.
- The first SWEEP cycle is the cycle after b[N−1] is accepted. Each sweep takes exactly N cycles.
- out_valid rises in the cycle after the final sweep's i=N−1 update. With out_ready held high, latency from the last accepted b to the first x_out is s·N+1 cycles, where s is the sweep count.
- Output throughput is 1 word/cycle when out_ready=1. After the last handshake, out_valid=0 and in_ready=1 in the next cycle.
- Gaps in in_en during LOAD are allowed; the word count alone determines the end of LOAD.
- Reset asserted in any state returns the block immediately to reset values. Partial input and output are discarded. No x word is emitted after reset.
- The iter_max and tol pins may change after b[0] with no effect until the next block.

## Structure
- gsim_pkg holds: the state enum, RECIP=52429, RSH=20, the band coefficients (20, 13, 6, 1) and the accumulator guard width (6).
- gsim_pe is the sub-module holding the combinational update datapath. Inputs: b_i, the six neighbours and x_old. Outputs: x_new (saturated) and Δ.
- The gsim_gen top holds the FSM, the b and x register arrays, the counters, and neighbour selection with boundary zeroing.

## Test plan
- Standard 16-word pattern, iter_max=255, tol=0 → each x_out within 2^−10 of the golden solution (x[0] ≈ −2248.2621, x[15] ≈ −2286.5305). Sum of squared residuals < 1e−3.
- N=4, b={20,0,0,0}, iter_max=1 → x_out[0]=0x00010000, x_out[1]=0x0000A666, x_out[2]=0x00001F5B. iter_cnt=1, converged=0 (max Δ above tol=0).
- All b=0, iter_max=10, tol=0 → after 1 sweep, converged=1, iter_cnt=1, all x_out=0. First out_valid appears N+1 cycles after the last b.
- tol=0, iter_max=3, standard pattern → iter_cnt=3, converged=0. Output appears 3N+1 cycles after the last b.
- out_ready low for 5 cycles at k=7 → x_out holds x[7]. Exactly N words are emitted, none duplicated. in_ready stays 0 until the final handshake.
- reset pulsed mid-SWEEP, and in_en asserted during OUT → all outputs return to reset values and the ignored words are absent. The next block produces the correct result.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared types and constants for the GSIM Gauss-Seidel solver.
package gsim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        OUT   = 2'd3
    } state_t;

    // 1/20 approximated as RECIP / 2^RSH
    localparam int RECIP = 52429;
    localparam int RSH   = 20;

    // Band coefficients: diagonal, offset 1, offset 2, offset 3
    localparam int C_DIAG = 20;
    localparam int C1     = 13;
    localparam int C2     = 6;
    localparam int C3     = 1;

    // Extra accumulator bits above XW so the weighted sum cannot overflow
    localparam int GUARD = 6;

endpackage

// File: rtl/gsim_pe.sv
// Combinational Gauss-Seidel update for one unknown: weighted neighbour sum,
// divide by the diagonal via reciprocal multiply, saturate, and |delta|.
module gsim_pe #(
    parameter int BW   = 16,
    parameter int FRAC = 16,
    parameter int XW   = 32
) (
    input  logic [BW-1:0] b_i,
    input  logic [XW-1:0] xm1,
    input  logic [XW-1:0] xp1,
    input  logic [XW-1:0] xm2,
    input  logic [XW-1:0] xp2,
    input  logic [XW-1:0] xm3,
    input  logic [XW-1:0] xp3,
    input  logic [XW-1:0] x_old,
    output logic [XW-1:0] x_new,
    output logic [XW:0]   delta
);
    import gsim_pkg::*;

    localparam int SW = XW + GUARD;
    localparam int PW = SW + 18;

    localparam logic signed [SW-1:0] K1   = SW'(C1);
    localparam logic signed [SW-1:0] K2   = SW'(C2);
    localparam logic signed [SW-1:0] K3   = SW'(C3);
    localparam logic signed [PW-1:0] KR   = PW'(RECIP);
    localparam logic signed [PW-1:0] QMAX = PW'((64'sd1 <<< (XW-1)) - 64'sd1);
    localparam logic signed [PW-1:0] QMIN = ~QMAX;

    logic signed [SW-1:0] bs;
    logic signed [SW-1:0] s;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    logic signed [XW:0]   d;

    function automatic logic signed [SW-1:0] sx(input logic [XW-1:0] v);
        return {{GUARD{v[XW-1]}}, v};
    endfunction

    // Weighted sum, reciprocal divide with floor, saturation and |x_new - x_old|
    always_comb begin
        bs = {{(SW-BW){b_i[BW-1]}}, b_i};
        s  = (bs <<< FRAC)
           + K1 * (sx(xm1) + sx(xp1))
           - K2 * (sx(xm2) + sx(xp2))
           + K3 * (sx(xm3) + sx(xp3));
        p  = signed'({{(PW-SW){s[SW-1]}}, s}) * KR;
        q  = p >>> RSH;
        if (q > QMAX)
            x_new = QMAX[XW-1:0];
        else if (q < QMIN)
            x_new = QMIN[XW-1:0];
        else
            x_new = q[XW-1:0];
        d     = signed'({x_new[XW-1], x_new}) - signed'({x_old[XW-1], x_old});
        delta = d[XW] ? (-d) : d;
    end

endmodule

// File: rtl/gsim_gen.sv
// Parametrised Gauss-Seidel solver for the 7-band system, with b input
// stream, x output stream, iteration limit and tolerance early exit.
//
//  state | meaning
//  IDLE  | waiting for b[0]
//  LOAD  | collecting b[1..N-1]
//  SWEEP | one unknown updated per cycle, in place
//  OUT   | streaming x[0..N-1]
module gsim_gen #(
    parameter int N    = 16,
    parameter int BW   = 16,
    parameter int FRAC = 16,
    parameter int XW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [BW-1:0] b_in,
    output logic          in_ready,
    input  logic [7:0]    iter_max,
    input  logic [XW-1:0] tol,
    output logic          out_valid,
    output logic [XW-1:0] x_out,
    input  logic          out_ready,
    output logic          busy,
    output logic [7:0]    iter_cnt,
    output logic          converged
);
    import gsim_pkg::*;

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [BW-1:0] b_mem [N];
    logic [XW-1:0] x_mem [N];
    logic [7:0]    iter_lim;
    logic [XW-1:0] tol_r;
    logic [XW:0]   max_d, max_cur, delta;
    logic [XW-1:0] xm1, xp1, xm2, xp2, xm3, xp3, x_old, x_new;
    logic [BW-1:0] b_cur;
    logic          accept, last, conv_now, sweep_done;

    assign accept     = in_en && in_ready;
    assign last       = (idx == LAST);
    assign max_cur    = (idx == '0) ? delta : ((delta > max_d) ? delta : max_d);
    assign conv_now   = (max_cur <= {1'b0, tol_r});
    assign sweep_done = last && (conv_now || ((iter_cnt + 8'd1) >= iter_lim));

    // Neighbour selection; indices outside 0..N-1 read as zero
    always_comb begin
        xm1 = '0; xp1 = '0; xm2 = '0; xp2 = '0; xm3 = '0; xp3 = '0; x_old = '0;
        for (int j = 0; j < N; j++) begin
            if (j == int'(idx) - 1) xm1 = x_mem[j];
            if (j == int'(idx) + 1) xp1 = x_mem[j];
            if (j == int'(idx) - 2) xm2 = x_mem[j];
            if (j == int'(idx) + 2) xp2 = x_mem[j];
            if (j == int'(idx) - 3) xm3 = x_mem[j];
            if (j == int'(idx) + 3) xp3 = x_mem[j];
            if (j == int'(idx))     x_old = x_mem[j];
        end
        b_cur = b_mem[idx];
    end

    gsim_pe #(.BW(BW), .FRAC(FRAC), .XW(XW)) u_pe (
        .b_i   (b_cur),
        .xm1   (xm1),
        .xp1   (xp1),
        .xm2   (xm2),
        .xp2   (xp2),
        .xm3   (xm3),
        .xp3   (xp3),
        .x_old (x_old),
        .x_new (x_new),
        .delta (delta)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)             state_nxt = LOAD;
            LOAD:    if (accept && last)     state_nxt = SWEEP;
            SWEEP:   if (sweep_done)         state_nxt = OUT;
            OUT:     if (out_ready && last)  state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE) || (state == LOAD);
        out_valid = (state == OUT);
        busy      = (state == SWEEP) || (state == OUT);
        x_out     = (state == OUT) ? x_mem[idx] : '0;
    end

    // Index counter, sweep bookkeeping and per-block configuration latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            iter_cnt  <= '0;
            converged <= 1'b0;
            iter_lim  <= 8'd1;
            tol_r     <= '0;
            max_d     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    idx       <= IW'(1);
                    iter_cnt  <= '0;
                    converged <= 1'b0;
                    iter_lim  <= (iter_max == 8'd0) ? 8'd1 : iter_max;
                    tol_r     <= tol;
                end
                LOAD: if (accept) idx <= last ? '0 : idx + 1'b1;
                SWEEP: begin
                    max_d <= max_cur;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        iter_cnt  <= iter_cnt + 8'd1;
                        converged <= conv_now;
                    end
                end
                OUT: if (out_ready) idx <= last ? '0 : idx + 1'b1;
                default: idx <= '0;
            endcase
        end
    end

    // b capture and in-place x update; x is cleared when b[0] arrives
    always_ff @(posedge clk) begin
        if (accept) b_mem[idx] <= b_in;
        if (accept && state == IDLE) begin
            for (int j = 0; j < N; j++) x_mem[j] <= '0;
        end else if (state == SWEEP) begin
            x_mem[idx] <= x_new;
        end
    end

endmodule

// File: tb/tb_gsim_gen.sv
module tb_gsim_gen;

    logic        clk = 0;
    logic        reset;
    always #5 clk = ~clk;

    // N=16 instance
    logic        in_en, in_ready, out_valid, out_ready, busy, converged;
    logic [15:0] b_in;
    logic [7:0]  iter_max, iter_cnt;
    logic [31:0] tol, x_out;

    // N=4 instance
    logic        in_en4, ready4, valid4, out_ready4, busy4, conv4;
    logic [15:0] b4;
    logic [7:0]  it4, cnt4;
    logic [31:0] tol4, x4;

    gsim_gen #(.N(16), .BW(16), .FRAC(16), .XW(32)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(in_ready),
        .iter_max(iter_max), .tol(tol), .out_valid(out_valid), .x_out(x_out),
        .out_ready(out_ready), .busy(busy), .iter_cnt(iter_cnt), .converged(converged)
    );

    gsim_gen #(.N(4), .BW(16), .FRAC(16), .XW(32)) dut4 (
        .clk(clk), .reset(reset), .in_en(in_en4), .b_in(b4), .in_ready(ready4),
        .iter_max(it4), .tol(tol4), .out_valid(valid4), .x_out(x4),
        .out_ready(out_ready4), .busy(busy4), .iter_cnt(cnt4), .converged(conv4)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] b;
        logic [31:0] x;
    } vec_t;
    vec_t tbl[12];

    int     tb_b[16];
    longint mx[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint gx(input int j);
        if (j < 0 || j > 15) return 0;
        return mx[j];
    endfunction

    // Reference Gauss-Seidel straight from the update equation
    task automatic model(input int it, input longint tl, output int ecnt, output bit econv);
        longint s, xn, d, mxd;
        int lim;
        lim = (it == 0) ? 1 : it;
        for (int i = 0; i < 16; i++) mx[i] = 0;
        ecnt = 0;
        econv = 0;
        do begin
            mxd = 0;
            for (int i = 0; i < 16; i++) begin
                s = longint'(tb_b[i]) * 65536
                  + 13 * (gx(i-1) + gx(i+1))
                  - 6 * (gx(i-2) + gx(i+2))
                  + (gx(i-3) + gx(i+3));
                xn = (s * 52429) >>> 20;
                if (xn > 64'sd2147483647) xn = 64'sd2147483647;
                if (xn < -64'sd2147483648) xn = -64'sd2147483648;
                d = xn - mx[i];
                if (d < 0) d = -d;
                if (d > mxd) mxd = d;
                mx[i] = xn;
            end
            ecnt++;
            econv = (mxd <= tl);
        end while (!econv && ecnt < lim);
    endtask

    task automatic send16(input int it, input int tl);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                in_en = 0;
                b_in = 16'h7FFF;
                @(posedge clk); #1;
            end
            in_en = 1;
            b_in = 16'(tb_b[i]);
            if (i == 0) begin
                iter_max = 8'(it);
                tol = 32'(tl);
            end else begin
                iter_max = 8'd1;
                tol = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
        end
        in_en = 0;
    endtask

    task automatic wait_out(input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic read16(input bit stall, input bit junk);
        if (junk) begin
            in_en = 1;
            b_in = 16'h1234;
        end
        for (int k = 0; k < 16; k++) begin
            check("x_out", x_out, 32'(mx[k]));
            check("out_valid", {31'd0, out_valid}, 32'd1);
            if (stall && k == 7) begin
                out_ready = 0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("x_hold", x_out, 32'(mx[7]));
                    check("in_ready_stall", {31'd0, in_ready}, 32'd0);
                end
                out_ready = 1;
            end
            @(posedge clk); #1;
        end
        in_en = 0;
        check("out_valid_end", {31'd0, out_valid}, 32'd0);
        check("in_ready_end", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run16(input int it, input int tl, input bit stall, input bit junk);
        int ecnt;
        bit econv;
        model(it, longint'(tl), ecnt, econv);
        send16(it, tl);
        wait_out(ecnt * 16 + 1);
        check("iter_cnt", {24'd0, iter_cnt}, 32'(ecnt));
        check("converged", {31'd0, converged}, {31'd0, econv});
        check("busy_out", {31'd0, busy}, 32'd1);
        read16(stall, junk);
    endtask

    task automatic pattern(input int sel);
        for (int i = 0; i < 16; i++) begin
            case (sel)
                0: tb_b[i] = 1000 * (i - 7) + 3 * i * i;
                1: tb_b[i] = (i % 3) * 5000 - 4000;
                default: tb_b[i] = 0;
            endcase
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_x_out"},     x_out,              32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_iter_cnt"},  {24'd0, iter_cnt},  32'd0);
        check({tag, "_converged"}, {31'd0, converged}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // N=4 directed vectors, one sweep each: {b, expected x}
        tbl[0]  = '{16'd20,     32'h0001_0000};
        tbl[1]  = '{16'd0,      32'h0000_A666};
        tbl[2]  = '{16'd0,      32'h0000_1F5B};
        tbl[3]  = '{16'd0,      32'hFFFF_EF42};
        tbl[4]  = '{16'd0,      32'h0000_0000};
        tbl[5]  = '{16'd0,      32'h0000_0000};
        tbl[6]  = '{16'd0,      32'h0000_0000};
        tbl[7]  = '{16'd20,     32'h0001_0000};
        tbl[8]  = '{16'hFFEC,   32'hFFFE_FFFF};
        tbl[9]  = '{16'd0,      32'hFFFF_5998};
        tbl[10] = '{16'd0,      32'hFFFF_E0A3};
        tbl[11] = '{16'd0,      32'h0000_10BC};

        reset = 1;
        in_en = 0; b_in = 0; iter_max = 0; tol = 0; out_ready = 1;
        in_en4 = 0; b4 = 0; it4 = 0; tol4 = 0; out_ready4 = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        check("rst4_in_ready", {31'd0, ready4}, 32'd1);
        check("rst4_x_out", x4, 32'd0);
        reset = 0;
        @(posedge clk); #1;

        // Table-driven N=4 blocks
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 4; i++) begin
                in_en4 = 1;
                b4 = tbl[blk*4+i].b;
                it4 = 8'd1;
                tol4 = 32'd0;
                @(posedge clk); #1;
            end
            in_en4 = 0;
            lat = 1;
            while (!valid4 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check("lat4", 32'(lat), 32'd5);
            check("iter_cnt4", {24'd0, cnt4}, 32'd1);
            check("converged4", {31'd0, conv4}, 32'd0);
            for (int i = 0; i < 4; i++) begin
                check("x4", x4, tbl[blk*4+i].x);
                @(posedge clk); #1;
            end
            check("valid4_end", {31'd0, valid4}, 32'd0);
        end

        // N=16 scenarios
        pattern(0); run16(255, 0, 1'b1, 1'b0);
        pattern(0); run16(3, 0, 1'b0, 1'b0);
        pattern(2); run16(10, 0, 1'b0, 1'b0);
        pattern(1); run16(255, 65536, 1'b0, 1'b0);
        pattern(0); run16(0, 0, 1'b0, 1'b0);

        // Reset in the middle of the second sweep
        pattern(0);
        send16(255, 0);
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_iter_cnt", {24'd0, iter_cnt}, 32'd1);
        reset = 1;
        #1;
        check_reset_vals("mid");
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        check_reset_vals("post");

        // Words offered during OUT must be ignored
        pattern(1); run16(3, 0, 1'b0, 1'b1);
        pattern(2); run16(10, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
